// File: rtl/stage_sequencer.sv
// Multi-cycle RV32I control FSM: walks each instruction through fetch..pc-update,
// halts on SYSTEM/illegal opcodes, data-memory timeout or external request.
module stage_sequencer #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  opcode,
  input  logic        fetch_ready,
  input  logic        mem_ready,
  input  logic        halt_request,
  output logic [2:0]  stage,
  output logic        instr_retired,
  output logic        halted,
  output logic [2:0]  halt_cause,
  output logic [31:0] cycle_count,
  output logic [31:0] instret_count
);

  localparam int STAGE_WIDTH = 3;

  typedef enum logic [STAGE_WIDTH-1:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_EXECUTE = 3'd2,
    S_MEM     = 3'd3,
    S_REG_UPD = 3'd4,
    S_PC_UPD  = 3'd5,
    S_HALT    = 3'd7
  } stage_t;

  localparam logic [2:0] CAUSE_NONE    = 3'd0;
  localparam logic [2:0] CAUSE_EXT     = 3'd1;
  localparam logic [2:0] CAUSE_SYSTEM  = 3'd2;
  localparam logic [2:0] CAUSE_ILLEGAL = 3'd3;
  localparam logic [2:0] CAUSE_TIMEOUT = 3'd4;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  // Wraps to 0xFFFF when MEM_TIMEOUT is 0, but the compare is disabled then.
  localparam logic [15:0] TIMEOUT_LAST = 16'(MEM_TIMEOUT - 1);

  stage_t      state;
  logic        pending;
  logic [15:0] wait_cnt;
  logic        op_legal;

  always_comb begin
    op_legal = 1'b0;
    case (opcode)
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH,
      OP_LOAD, OP_STORE, OP_IMM, OP_REG: op_legal = 1'b1;
      default: op_legal = 1'b0;
    endcase
  end

  assign stage         = state;
  assign instr_retired = (state == S_PC_UPD);
  assign halted        = (state == S_HALT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_FETCH;
      halt_cause    <= CAUSE_NONE;
      cycle_count   <= '0;
      instret_count <= '0;
      pending       <= 1'b0;
      wait_cnt      <= '0;
    end else begin
      if (state != S_HALT) begin
        cycle_count <= cycle_count + 32'd1;
        if (halt_request) pending <= 1'b1;
      end
      case (state)
        S_FETCH: if (fetch_ready) state <= S_DECODE;
        S_DECODE: begin
          if (opcode == OP_SYSTEM) begin
            state      <= S_HALT;
            halt_cause <= CAUSE_SYSTEM;
          end else if (!op_legal) begin
            state      <= S_HALT;
            halt_cause <= CAUSE_ILLEGAL;
          end else begin
            state <= S_EXECUTE;
          end
        end
        S_EXECUTE: begin
          wait_cnt <= '0;
          state    <= (opcode == OP_LOAD || opcode == OP_STORE) ? S_MEM : S_REG_UPD;
        end
        S_MEM: begin
          // A ready arriving on the timeout cycle still completes the access.
          if (mem_ready) begin
            state <= S_REG_UPD;
          end else if (MEM_TIMEOUT != 0 && wait_cnt == TIMEOUT_LAST) begin
            state      <= S_HALT;
            halt_cause <= CAUSE_TIMEOUT;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        S_REG_UPD: state <= S_PC_UPD;
        S_PC_UPD: begin
          instret_count <= instret_count + 32'd1;
          if (pending || halt_request) begin
            state      <= S_HALT;
            halt_cause <= CAUSE_EXT;
          end else begin
            state <= S_FETCH;
          end
        end
        S_HALT: state <= S_HALT;
        default: state <= S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_stage_sequencer.sv
// Scoreboard bench for stage_sequencer: expected stages queued as stimulus is driven.
module tb_stage_sequencer;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [6:0]  opcode = 7'b0010011;
  logic        fetch_ready = 1'b0;
  logic        mem_ready = 1'b0;
  logic        halt_request = 1'b0;
  logic [2:0]  stage;
  logic        instr_retired;
  logic        halted;
  logic [2:0]  halt_cause;
  logic [31:0] cycle_count;
  logic [31:0] instret_count;

  int vectors = 0;
  int miscompares = 0;
  logic [2:0] exp_q[$];

  stage_sequencer #(.MEM_TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .fetch_ready(fetch_ready),
    .mem_ready(mem_ready), .halt_request(halt_request), .stage(stage),
    .instr_retired(instr_retired), .halted(halted), .halt_cause(halt_cause),
    .cycle_count(cycle_count), .instret_count(instret_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Compare the current stage and its decodes against the oldest queued expectation.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [2:0] e;
      e = exp_q.pop_front();
      check("stage", 32'(stage), 32'(e));
      check("retired", 32'(instr_retired), 32'(e == 3'd5));
      check("halted", 32'(halted), 32'(e == 3'd7));
    end
  end

  task automatic cyc(input logic [2:0] exp_stage, input logic fr = 1'b0,
                     input logic mr = 1'b0, input logic hr = 1'b0);
    fetch_ready  = fr;
    mem_ready    = mr;
    halt_request = hr;
    exp_q.push_back(exp_stage);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    fetch_ready = 1'b0; mem_ready = 1'b0; halt_request = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_stage", 32'(stage), 32'd0);
    check("rst_cause", 32'(halt_cause), 32'd0);
    check("rst_cycles", cycle_count, 32'd0);
    check("rst_instret", instret_count, 32'd0);
  endtask

  initial begin
    // ADDI, fetch immediately ready
    do_reset();
    opcode = 7'b0010011;
    cyc(0, 1); cyc(1); cyc(2); cyc(4); cyc(5);
    check("addi_stage", 32'(stage), 32'd0);
    check("addi_instret", instret_count, 32'd1);
    check("addi_cycles", cycle_count, 32'd5);

    // LOAD with two fetch wait states; ready on the timeout cycle still wins
    opcode = 7'b0000011;
    cyc(0, 0); cyc(0, 0); cyc(0, 1); cyc(1); cyc(2);
    cyc(3, 0, 0); cyc(3, 0, 0); cyc(3, 0, 0); cyc(3, 0, 1);
    cyc(4); cyc(5);
    check("load_stage", 32'(stage), 32'd0);
    check("load_instret", instret_count, 32'd2);
    check("load_cycles", cycle_count, 32'd16);

    // STORE timeout after 4 MEM cycles, then counters frozen
    do_reset();
    opcode = 7'b0100011;
    cyc(0, 1); cyc(1); cyc(2); cyc(3); cyc(3); cyc(3); cyc(3);
    check("to_cause", 32'(halt_cause), 32'd4);
    check("to_cycles", cycle_count, 32'd7);
    for (int i = 0; i < 20; i++) cyc(7, 1, 1, 0);
    check("to_frozen", cycle_count, 32'd7);
    check("to_cause_held", 32'(halt_cause), 32'd4);
    check("to_instret", instret_count, 32'd0);

    // Reset out of HALT
    do_reset();

    // Illegal opcode, with an earlier halt request that must not override the fault
    opcode = 7'b1111111;
    cyc(0, 1, 0, 1); cyc(1);
    cyc(7);
    check("ill_cause", 32'(halt_cause), 32'd3);
    check("ill_instret", instret_count, 32'd0);

    // SYSTEM opcode
    do_reset();
    opcode = 7'b1110011;
    cyc(0, 1); cyc(1); cyc(7);
    check("sys_cause", 32'(halt_cause), 32'd2);
    check("sys_instret", instret_count, 32'd0);

    // Halt pulse during EXECUTE of ADD: instruction completes first
    do_reset();
    opcode = 7'b0110011;
    cyc(0, 1); cyc(1); cyc(2, 0, 0, 1); cyc(4); cyc(5); cyc(7);
    check("ext_cause", 32'(halt_cause), 32'd1);
    check("ext_instret", instret_count, 32'd1);
    check("ext_cycles", cycle_count, 32'd5);

    // Halt pulse sampled during PC_UPDATE itself
    do_reset();
    opcode = 7'b0010011;
    cyc(0, 1); cyc(1); cyc(2); cyc(4); cyc(5, 0, 0, 1); cyc(7);
    check("pcu_cause", 32'(halt_cause), 32'd1);

    // Reset asserted while in MEM
    do_reset();
    opcode = 7'b0000011;
    cyc(0, 1); cyc(1); cyc(2); cyc(3);
    do_reset();

    // instret wrap: preload near the top, then retire once
    opcode = 7'b0010011;
    cyc(0, 1); cyc(1); cyc(2); cyc(4);
    force dut.instret_count = 32'hFFFF_FFFF;
    #1;
    release dut.instret_count;
    cyc(5);
    check("wrap_instret", instret_count, 32'd0);
    check("wrap_stage", 32'(stage), 32'd0);

    @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/stage_sequencer.md
Name: stage_sequencer

Overview:
- Multi-cycle control FSM for the RV32I core. Generates the `stage` value consumed by the write-back control, ALU, memory interface and PC logic.
- Steps each instruction through FETCH, DECODE, EXECUTE, optional MEM, REGISTER_UPDATE and PC_UPDATE.
- Handles instruction and data memory wait states, illegal or SYSTEM opcodes, external halt requests and data-memory timeouts.
- Maintains cycle and retired-instruction counters.

Parameters:
- MEM_TIMEOUT, 255: maximum number of cycles spent waiting in MEM for mem_ready. 0 disables the timeout. Valid range 0..65535.

Ports:
- clk  input  1  core clock
- reset  input  1  synchronous, active-high reset
- opcode  input  7  instr[6:0]; upstream holds it stable from DECODE through PC_UPDATE
- fetch_ready  input  1  instruction word valid; sampled only in FETCH
- mem_ready  input  1  data access complete; sampled only in MEM
- halt_request  input  1  external halt; level or pulse
- stage  output  3  current stage, `STAGE_WIDTH
- instr_retired  output  1  high during PC_UPDATE
- halted  output  1  high while stage is HALT
- halt_cause  output  3  0 running, 1 external, 2 SYSTEM opcode, 3 illegal opcode, 4 mem timeout
- cycle_count  output  32  non-halted cycles since reset
- instret_count  output  32  retired instructions since reset

Behaviour:
- Stage encoding (arch_defines STAGE_* values): FETCH=0, DECODE=1, EXECUTE=2, MEM=3, REGISTER_UPDATE=4, PC_UPDATE=5, HALT=7. Value 6 is unused; if reached, go to FETCH on the next cycle.
- Reset (synchronous, dominates everything, including mid-instruction and HALT):
  - stage=FETCH, halt_cause=0.
  - cycle_count=0, instret_count=0.
  - pending-halt flag cleared, timeout counter cleared.
- FETCH: stay while fetch_ready=0; go to DECODE on the clock edge where fetch_ready=1. No timeout applies.
- DECODE: exactly 1 cycle.
  - SYSTEM (1110011) -> HALT, cause 2.
  - Opcode not in {0110111, 0010111, 1101111, 1100111, 1100011, 0000011, 0100011, 0010011, 0110011} -> HALT, cause 3.
  - Otherwise -> EXECUTE.
- EXECUTE: exactly 1 cycle. LOAD (0000011) or STORE (0100011) -> MEM; all other opcodes -> REGISTER_UPDATE.
- MEM:
  - 16-bit wait counter clears on entry and increments each cycle mem_ready=0.
  - mem_ready=1 -> REGISTER_UPDATE, even if the timeout is reached in the same cycle (ready wins).
  - MEM_TIMEOUT!=0 and counter==MEM_TIMEOUT-1 with mem_ready=0 -> HALT, cause 4. MEM is therefore occupied for at most MEM_TIMEOUT cycles.
- REGISTER_UPDATE: exactly 1 cycle, always entered, including for store and branch. Write gating belongs to downstream logic. -> PC_UPDATE.
- PC_UPDATE: exactly 1 cycle, instr_retired=1.
  - Pending halt -> HALT, cause 1.
  - Otherwise -> FETCH.
  - instret_count increments on the exit edge in both cases.
- halt_request:
  - Any cycle with halt_request=1 while not HALT sets the pending flag.
  - Takes effect only at the PC_UPDATE exit, so the current instruction always completes.
  - A request sampled during PC_UPDATE itself also takes effect on that exit.
- Fault priority: a DECODE or MEM fault halts immediately, the cause is the fault code, and the pending flag is ignored.
- HALT: sticky until reset. halted=1. halt_cause is frozen. cycle_count stops. instr_retired=0.
- Counters: 32-bit, wrap modulo 2^32 with no flag. cycle_count increments every cycle stage!=HALT, including the cycle that transitions into HALT.
- Registered outputs: stage, halt_cause, counters. Combinational decodes of registered stage: instr_retired, halted.

Test Plan:
- ADDI (opcode 0010011), fetch_ready=1 immediately -> stage sequence 0,1,2,4,5,0; instr_retired high exactly 1 cycle; instret_count=1 and cycle_count=5 after returning to FETCH.
- LOAD (0000011), mem_ready held low 3 cycles then high -> sequence 0,1,2,3,3,3,3,4,5,0; 9 cycles total; REGISTER_UPDATE entered the cycle after mem_ready=1.
- STORE with MEM_TIMEOUT=4, mem_ready stuck 0 -> 4 cycles in MEM, then stage=7, halt_cause=4, halted=1; cycle_count frozen over 20 further cycles.
- Opcode 1111111 in DECODE -> stage=7, halt_cause=3. Opcode 1110011 -> halt_cause=2. instret_count unchanged in both.
- halt_request 1-cycle pulse during EXECUTE of ADD (0110011) -> instruction completes through PC_UPDATE, instret_count+1, then stage=7, halt_cause=1.
- Assert reset in MEM and again in HALT -> next cycle stage=0, counters=0, halt_cause=0. Separately preload the counters near wrap (e.g. run to 0xFFFFFFFF via forced instret) -> instret_count wraps to 0.
